// File: rtl/acq_pkg.sv
// Shared definitions for the acquisition path.
// Provides the mode encoding for analog/LA sample sources, the default sample
// width, the {max, min} pair type and the window controller state type.
package acq_pkg;

    localparam int unsigned DATA_W_DEF = 8;

    // Source/combine mode: analog uses magnitude compare, LA uses OR/AND.
    localparam logic MODE_ANALOG = 1'b0;
    localparam logic MODE_LA     = 1'b1;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] max_v;
        logic [DATA_W_DEF-1:0] min_v;
    } sample_pair_t;

    typedef enum logic {
        StEmpty,
        StAccum
    } win_state_t;

endpackage

// File: rtl/minmax_acc.sv
// Per-sample min/max combine, purely combinational.
// Ports:
//   mode     - MODE_ANALOG: unsigned magnitude compare; MODE_LA: OR into max, AND into min
//   first    - sample opens a window; both accumulators take the sample as-is
//   s        - current sample
//   acc_max  - running max (analog) / OR (LA)
//   acc_min  - running min (analog) / AND (LA)
//   nxt_max  - combined max/OR including s
//   nxt_min  - combined min/AND including s
module minmax_acc
    import acq_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              mode,
    input  logic              first,
    input  logic [DATA_W-1:0] s,
    input  logic [DATA_W-1:0] acc_max,
    input  logic [DATA_W-1:0] acc_min,
    output logic [DATA_W-1:0] nxt_max,
    output logic [DATA_W-1:0] nxt_min
);

    always_comb begin
        nxt_max = acc_max;
        nxt_min = acc_min;
        if (first) begin
            nxt_max = s;
            nxt_min = s;
        end else if (mode == MODE_LA) begin
            // Bitwise accumulation keeps a single-sample glitch on any line.
            nxt_max = acc_max | s;
            nxt_min = acc_min & s;
        end else begin
            nxt_max = (s >= acc_max) ? s : acc_max;
            nxt_min = (s <= acc_min) ? s : acc_min;
        end
    end

endmodule

// File: rtl/min_max_window.sv
// Windowed peak detector: reduces a strobed sample stream to one {max, min}
// pair per window of L = max(WIN_LEN, 1) samples.
// Ports:
//   CLK          - sample clock, rising edge
//   CLR          - asynchronous active-low reset
//   EN           - sample strobe
//   RESTART      - synchronous abort of the current window
//   LA_SOURSE    - 0: analog (A_DATA_IN, compare); 1: LA (LA_DATA_IN, OR/AND)
//   A_DATA_IN    - analog sample
//   LA_DATA_IN   - logic-analyzer sample
//   WIN_LEN      - samples per window, 0 treated as 1
//   MAX_DATA_OUT - max/OR of the last completed window
//   MIN_DATA_OUT - min/AND of the last completed window
//   OUT_VALID    - one-cycle pulse when the outputs update
//   WIN_BUSY     - window holds at least one sample but is not complete
module min_max_window
    import acq_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned WIN_W  = 10
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              EN,
    input  logic              RESTART,
    input  logic              LA_SOURSE,
    input  logic [DATA_W-1:0] A_DATA_IN,
    input  logic [DATA_W-1:0] LA_DATA_IN,
    input  logic [WIN_W-1:0]  WIN_LEN,
    output logic [DATA_W-1:0] MAX_DATA_OUT,
    output logic [DATA_W-1:0] MIN_DATA_OUT,
    output logic              OUT_VALID,
    output logic              WIN_BUSY
);

    win_state_t        state;
    logic [WIN_W-1:0]  count;
    logic [WIN_W-1:0]  len_lat;
    logic              mode_lat;
    logic [DATA_W-1:0] acc_max;
    logic [DATA_W-1:0] acc_min;

    logic              first;
    logic [WIN_W-1:0]  live_len;
    logic [WIN_W-1:0]  eff_len;
    logic              eff_mode;
    logic [WIN_W-1:0]  cnt_nxt;
    logic [DATA_W-1:0] sample;
    logic              done;
    logic [DATA_W-1:0] nxt_max;
    logic [DATA_W-1:0] nxt_min;

    // A RESTART makes the current sample open a new window, so it takes the
    // live length/mode exactly like a sample arriving in EMPTY.
    always_comb begin
        first    = RESTART || (state == StEmpty);
        live_len = (WIN_LEN == '0) ? WIN_W'(1) : WIN_LEN;
        eff_len  = first ? live_len : len_lat;
        eff_mode = first ? LA_SOURSE : mode_lat;
        sample   = (eff_mode == MODE_LA) ? LA_DATA_IN : A_DATA_IN;
        // count < len_lat while accumulating, so the increment cannot wrap.
        cnt_nxt  = first ? WIN_W'(1) : count + WIN_W'(1);
        done     = EN && (cnt_nxt == eff_len);
    end

    minmax_acc #(
        .DATA_W (DATA_W)
    ) u_acc (
        .mode    (eff_mode),
        .first   (first),
        .s       (sample),
        .acc_max (acc_max),
        .acc_min (acc_min),
        .nxt_max (nxt_max),
        .nxt_min (nxt_min)
    );

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state        <= StEmpty;
            count        <= '0;
            len_lat      <= '0;
            mode_lat     <= MODE_ANALOG;
            acc_max      <= '0;
            acc_min      <= '0;
            MAX_DATA_OUT <= '0;
            MIN_DATA_OUT <= '0;
            OUT_VALID    <= 1'b0;
        end else begin
            OUT_VALID <= 1'b0;
            if (EN) begin
                mode_lat <= eff_mode;
                len_lat  <= eff_len;
                acc_max  <= nxt_max;
                acc_min  <= nxt_min;
                if (done) begin
                    MAX_DATA_OUT <= nxt_max;
                    MIN_DATA_OUT <= nxt_min;
                    OUT_VALID    <= 1'b1;
                    state        <= StEmpty;
                    count        <= '0;
                end else begin
                    state <= StAccum;
                    count <= cnt_nxt;
                end
            end else if (RESTART) begin
                state <= StEmpty;
                count <= '0;
            end
        end
    end

    assign WIN_BUSY = (state == StAccum);

endmodule

// File: tb/tb_min_max_window.sv
module tb_min_max_window;
    import acq_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned WW = 10;

    logic          CLK;
    logic          CLR;
    logic          EN;
    logic          RESTART;
    logic          LA_SOURSE;
    logic [DW-1:0] A_DATA_IN;
    logic [DW-1:0] LA_DATA_IN;
    logic [WW-1:0] WIN_LEN;
    logic [DW-1:0] MAX_DATA_OUT;
    logic [DW-1:0] MIN_DATA_OUT;
    logic          OUT_VALID;
    logic          WIN_BUSY;

    int unsigned tests = 0;
    int unsigned fails = 0;

    min_max_window #(
        .DATA_W (DW),
        .WIN_W  (WW)
    ) dut (
        .CLK          (CLK),
        .CLR          (CLR),
        .EN           (EN),
        .RESTART      (RESTART),
        .LA_SOURSE    (LA_SOURSE),
        .A_DATA_IN    (A_DATA_IN),
        .LA_DATA_IN   (LA_DATA_IN),
        .WIN_LEN      (WIN_LEN),
        .MAX_DATA_OUT (MAX_DATA_OUT),
        .MIN_DATA_OUT (MIN_DATA_OUT),
        .OUT_VALID    (OUT_VALID),
        .WIN_BUSY     (WIN_BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: the open window is a plain list of samples, reduced
    // when it reaches its latched length.
    logic [DW-1:0] win_q[$];
    logic          m_mode;
    int unsigned   m_len;
    logic [DW-1:0] m_max;
    logic [DW-1:0] m_min;
    logic          m_valid;

    task automatic model_reset();
        win_q.delete();
        m_mode  = MODE_ANALOG;
        m_len   = 1;
        m_max   = '0;
        m_min   = '0;
        m_valid = 1'b0;
    endtask

    task automatic model_step(input logic en, input logic restart, input logic mode,
                              input logic [DW-1:0] a, input logic [DW-1:0] la,
                              input logic [WW-1:0] wl);
        m_valid = 1'b0;
        if (restart) win_q.delete();
        if (en) begin
            if (win_q.size() == 0) begin
                m_mode = mode;
                m_len  = (wl == 0) ? 1 : int'(wl);
            end
            win_q.push_back(m_mode ? la : a);
            if (win_q.size() == m_len) begin
                m_max = win_q[0];
                m_min = win_q[0];
                foreach (win_q[i]) begin
                    if (m_mode) begin
                        m_max = m_max | win_q[i];
                        m_min = m_min & win_q[i];
                    end else begin
                        if (win_q[i] > m_max) m_max = win_q[i];
                        if (win_q[i] < m_min) m_min = win_q[i];
                    end
                end
                m_valid = 1'b1;
                win_q.delete();
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    // Drive one cycle, let the edge happen, then sample away from it.
    task automatic apply(input logic en, input logic restart, input logic mode,
                         input logic [DW-1:0] a, input logic [DW-1:0] la,
                         input logic [WW-1:0] wl);
        EN         = en;
        RESTART    = restart;
        LA_SOURSE  = mode;
        A_DATA_IN  = a;
        LA_DATA_IN = la;
        WIN_LEN    = wl;
        @(posedge CLK);
        #1;
        model_step(en, restart, mode, a, la, wl);
    endtask

    typedef struct {
        logic         en;
        logic         restart;
        logic         mode;
        logic [7:0]   a;
        logic [7:0]   la;
        logic [9:0]   wl;
        logic         exp_valid;
        sample_pair_t exp_pair;
        logic         exp_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic en, input logic restart, input logic mode,
                                input logic [7:0] a, input logic [7:0] la, input logic [9:0] wl,
                                input logic v, input logic [7:0] mx, input logic [7:0] mn,
                                input logic busy);
        vec_t r;
        r.en             = en;
        r.restart        = restart;
        r.mode           = mode;
        r.a              = a;
        r.la             = la;
        r.wl             = wl;
        r.exp_valid      = v;
        r.exp_pair.max_v = mx;
        r.exp_pair.min_v = mn;
        r.exp_busy       = busy;
        return r;
    endfunction

    initial begin
        // Analog, length 4: 10,200,3,77
        vecs.push_back(mk(1, 0, 0, 10,  0, 4, 0, 0,   0, 1));
        vecs.push_back(mk(1, 0, 0, 200, 0, 4, 0, 0,   0, 1));
        vecs.push_back(mk(1, 0, 0, 3,   0, 4, 0, 0,   0, 1));
        vecs.push_back(mk(1, 0, 0, 77,  0, 4, 1, 200, 3, 0));
        vecs.push_back(mk(0, 0, 0, 0,   0, 4, 0, 200, 3, 0));
        // LA, length 3: glitch 0x80 kept in OR
        vecs.push_back(mk(1, 0, 1, 8'h55, 8'h01, 3, 0, 200,   3,     1));
        vecs.push_back(mk(1, 0, 1, 8'h55, 8'h80, 3, 0, 200,   3,     1));
        vecs.push_back(mk(1, 0, 1, 8'h55, 8'h01, 3, 1, 8'h81, 8'h00, 0));
        // Length 0 then 1, back-to-back pulses
        vecs.push_back(mk(1, 0, 0, 5, 0, 0, 1, 5, 5, 0));
        vecs.push_back(mk(1, 0, 0, 6, 0, 1, 1, 6, 6, 0));
        vecs.push_back(mk(1, 0, 0, 7, 0, 1, 1, 7, 7, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 7, 7, 0));
        // Gapped strobes; live mode/length changes mid-window are ignored
        vecs.push_back(mk(1, 0, 0, 9,   0,     4, 0, 7,  7, 1));
        vecs.push_back(mk(0, 0, 0, 250, 0,     4, 0, 7,  7, 1));
        vecs.push_back(mk(0, 0, 0, 0,   0,     4, 0, 7,  7, 1));
        vecs.push_back(mk(1, 0, 0, 2,   0,     4, 0, 7,  7, 1));
        vecs.push_back(mk(1, 0, 1, 50,  8'hFF, 1, 0, 7,  7, 1));
        vecs.push_back(mk(0, 0, 0, 251, 0,     4, 0, 7,  7, 1));
        vecs.push_back(mk(1, 0, 0, 8,   0,     4, 1, 50, 2, 0));
        // RESTART without EN, then RESTART with EN on the 3rd sample
        vecs.push_back(mk(1, 0, 0, 40,  0, 4, 0, 50,  2, 1));
        vecs.push_back(mk(0, 1, 0, 0,   0, 4, 0, 50,  2, 0));
        vecs.push_back(mk(1, 0, 0, 7,   0, 4, 0, 50,  2, 1));
        vecs.push_back(mk(1, 0, 0, 8,   0, 4, 0, 50,  2, 1));
        vecs.push_back(mk(1, 1, 0, 100, 0, 4, 0, 50,  2, 1));
        vecs.push_back(mk(1, 0, 0, 1,   0, 4, 0, 50,  2, 1));
        vecs.push_back(mk(1, 0, 0, 2,   0, 4, 0, 50,  2, 1));
        vecs.push_back(mk(1, 0, 0, 3,   0, 4, 1, 100, 1, 0));

        model_reset();
        CLR        = 1'b0;
        EN         = 1'b0;
        RESTART    = 1'b0;
        LA_SOURSE  = 1'b0;
        A_DATA_IN  = '0;
        LA_DATA_IN = '0;
        WIN_LEN    = 10'd4;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_max",   MAX_DATA_OUT, 0);
        check("reset_min",   MIN_DATA_OUT, 0);
        check("reset_valid", OUT_VALID,    0);
        check("reset_busy",  WIN_BUSY,     0);
        CLR = 1'b1;
        @(posedge CLK);
        #1;

        foreach (vecs[i]) begin
            apply(vecs[i].en, vecs[i].restart, vecs[i].mode, vecs[i].a, vecs[i].la, vecs[i].wl);
            check($sformatf("vec%0d_valid", i), OUT_VALID,    vecs[i].exp_valid);
            check($sformatf("vec%0d_max", i),   MAX_DATA_OUT, vecs[i].exp_pair.max_v);
            check($sformatf("vec%0d_min", i),   MIN_DATA_OUT, vecs[i].exp_pair.min_v);
            check($sformatf("vec%0d_busy", i),  WIN_BUSY,     vecs[i].exp_busy);
        end

        // Length changed 4->2 mid-window, then asynchronous clear.
        apply(1, 0, 0, 8'hFF, 0, 4);
        check("clr_busy1", WIN_BUSY, 1);
        apply(1, 0, 0, 8'h00, 0, 2);
        check("oldlen_valid", OUT_VALID, 0);
        check("oldlen_busy",  WIN_BUSY,  1);
        #2 CLR = 1'b0;
        #1;
        check("clr_max",   MAX_DATA_OUT, 0);
        check("clr_min",   MIN_DATA_OUT, 0);
        check("clr_valid", OUT_VALID,    0);
        check("clr_busy",  WIN_BUSY,     0);
        model_reset();
        #2 CLR = 1'b1;
        apply(1, 0, 0, 30, 0, 2);
        check("post_clr_busy",  WIN_BUSY,  1);
        check("post_clr_valid", OUT_VALID, 0);
        apply(1, 0, 0, 40, 0, 2);
        check("post_clr_valid2", OUT_VALID,    1);
        check("post_clr_max",    MAX_DATA_OUT, 40);
        check("post_clr_min",    MIN_DATA_OUT, 30);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic          r_en;
            logic          r_rs;
            logic          r_md;
            logic [WW-1:0] r_wl;
            r_en = ($urandom_range(0, 3) != 0);
            r_rs = ($urandom_range(0, 15) == 0);
            r_md = 1'($urandom_range(0, 1));
            r_wl = ($urandom_range(0, 19) == 0) ? WW'($urandom_range(0, 20))
                                                : WW'($urandom_range(0, 5));
            apply(r_en, r_rs, r_md, DW'($urandom), DW'($urandom), r_wl);
            check("rnd_valid", OUT_VALID, m_valid);
            check("rnd_max",   MAX_DATA_OUT, m_max);
            check("rnd_min",   MIN_DATA_OUT, m_min);
            check("rnd_busy",  WIN_BUSY, win_q.size() != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
